fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, value of o_if_pc while o_if_valid=0.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_pc  input  32  current fetch address from the PC register.
REQ-005 SHALL have port o_pc_stall  output  1  high = PC register holds; low = PC loads its next value.
REQ-006 SHALL have port i_flush  input  1  redirect from execute; discards in-flight and buffered fetches.
REQ-007 SHALL have port i_id_stall  input  1  decode cannot accept a new instruction this cycle.
REQ-008 SHALL have port o_imem_req  output  1  instruction memory read request.
REQ-009 SHALL have port o_imem_addr  output  32  word-aligned read address.
REQ-010 SHALL have port i_imem_rvalid  input  1  read data valid; asserted only while o_imem_req=1.
REQ-011 SHALL have port i_imem_rdata  input  32  read data.
REQ-012 SHALL have ports o_if_valid (1), o_if_pc (32), o_if_instr (32), outputs, registered IF/ID payload.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DRAIN, SKID; one read outstanding at most.
REQ-014 IDLE: o_imem_req=0, o_pc_stall=1; next state REQ unconditionally.
REQ-015 REQ/DRAIN: o_imem_req=1; o_imem_addr = {i_pc[31:2],2'b00} in REQ, latched address of the discarded request in DRAIN; address stable until i_imem_rvalid.
REQ-016 SKID: o_imem_req=0.
REQ-017 accept = state REQ & i_imem_rvalid & ~i_flush; o_pc_stall = ~(accept | i_flush), combinational.
REQ-018 On accept with (~o_if_valid | ~i_id_stall): load o_if_valid=1, o_if_pc=address, o_if_instr=i_imem_rdata next edge; stay REQ.
REQ-019 On accept with o_if_valid & i_id_stall: capture address/data into skid register; go SKID; IF/ID unchanged.
REQ-020 SKID & ~i_id_stall & ~i_flush: move skid into IF/ID (valid=1); go REQ.
REQ-021 o_if_valid & ~i_id_stall with nothing loaded that cycle: o_if_valid <= 0, pc/instr <= RESET_PC/0.
REQ-022 o_if_valid & i_id_stall: IF/ID held unchanged.
REQ-023 i_flush (any state): o_if_valid <= 0, skid invalidated; i_flush has priority over every load.
REQ-024 i_flush in REQ without i_imem_rvalid: go DRAIN; in REQ with i_imem_rvalid: data dropped, stay REQ.
REQ-025 DRAIN: on i_imem_rvalid drop data, go REQ; i_flush in DRAIN stays DRAIN.
REQ-026 i_flush in SKID or IDLE: go REQ (IDLE: REQ as normal).
REQ-027 Back-to-back: with zero-wait memory and no stall, one instruction per cycle, PC advancing every cycle.
REQ-028 No instruction SHALL be duplicated or lost except those discarded by i_flush.

Reset
REQ-029 i_reset_n=0 asynchronously forces state IDLE, o_if_valid=0, o_if_pc=RESET_PC, o_if_instr=0, skid invalid, o_imem_req=0.
REQ-030 Reset mid-request abandons the read; any i_imem_rvalid after reset release while o_imem_req=0 SHALL be ignored.
REQ-031 First request SHALL issue on the second rising edge after i_reset_n rises (one IDLE cycle).

Verification
REQ-032 Reset release, i_pc=0, rvalid tied 1, rdata=32'h00000013 -> o_if_valid=1, o_if_pc=0 after IDLE+1 edge; o_if_pc 4, 8, 12 on following cycles.
REQ-033 Memory latency 3 cycles, i_pc=0x100 -> o_imem_req high 3 cycles with addr 0x100, o_pc_stall=1 until rvalid cycle, then o_if_pc=0x100.
REQ-034 o_if_valid=1 (pc 0x10), i_id_stall=1, rvalid for 0x14 -> SKID, o_imem_req=0; stall released -> o_if_pc=0x14 next edge, no drop of 0x10 while stalled.
REQ-035 i_flush in REQ, rvalid arrives 2 cycles later for 0x20 -> DRAIN, data discarded, o_if_valid=0; next request uses new i_pc=0x80.
REQ-036 i_flush same cycle as rvalid and while in SKID -> no instruction delivered from either; o_pc_stall=0 in flush cycle.
REQ-037 i_reset_n low for 1 cycle mid-DRAIN -> all outputs return to reset values immediately; late rvalid ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller. Issues at most one instruction
//               memory read at a time, delivers fetched words into a
//               registered IF/ID payload, parks one extra word in a skid
//               register while decode is stalled, and discards in-flight
//               reads on a redirect (flush).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          clock, all state updates on rising edge
//   i_reset_n      asynchronous active-low reset
//   i_pc           current fetch address from the PC register
//   o_pc_stall     1 = PC register holds, 0 = PC loads its next value
//   i_flush        redirect from execute, discards in-flight/buffered fetches
//   i_id_stall     decode cannot accept a new instruction this cycle
//   o_imem_req     instruction memory read request
//   o_imem_addr    word-aligned read address
//   i_imem_rvalid  read data valid
//   i_imem_rdata   read data
//   o_if_valid     IF/ID payload valid
//   o_if_pc        IF/ID payload address (RESET_PC while invalid)
//   o_if_instr     IF/ID payload instruction (0 while invalid)
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_pc,
  output logic        o_pc_stall,
  input  logic        i_flush,
  input  logic        i_id_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SKID  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic [31:0] fetch_addr;
  logic        accept;

  assign fetch_addr = i_pc & ~32'h0000_0003;

  // A response is only taken while a live request is outstanding and no
  // redirect is in progress; a flush drops whatever arrives that cycle.
  assign accept     = (state_q == ST_REQ) & i_imem_rvalid & ~i_flush;
  assign o_pc_stall = ~(accept | i_flush);

  assign o_imem_req  = req_q;
  // While draining, the abandoned read must keep its original address until
  // memory answers, even though the PC has already moved to the new target.
  assign o_imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : fetch_addr;

  assign o_if_valid = if_valid_q;
  assign o_if_pc    = if_pc_q;
  assign o_if_instr = if_instr_q;

  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;

    // Next state
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (i_flush) begin
          if (!i_imem_rvalid) begin
            state_d      = ST_DRAIN;
            drain_addr_d = fetch_addr;
          end
        end else if (accept && if_valid_q && i_id_stall) begin
          state_d = ST_SKID;
        end
      end
      ST_DRAIN: begin
        if (!i_flush && i_imem_rvalid) state_d = ST_REQ;
      end
      ST_SKID: begin
        if (i_flush || !i_id_stall) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    // IF/ID payload and skid register; flush outranks every load.
    if (i_flush) begin
      if_valid_d   = 1'b0;
      if_pc_d      = RESET_PC;
      if_instr_d   = 32'h0;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      if (!if_valid_q || !i_id_stall) begin
        if_valid_d = 1'b1;
        if_pc_d    = fetch_addr;
        if_instr_d = i_imem_rdata;
      end else begin
        skid_valid_d = 1'b1;
        skid_pc_d    = fetch_addr;
        skid_instr_d = i_imem_rdata;
      end
    end else if (state_q == ST_SKID && skid_valid_q && !i_id_stall) begin
      if_valid_d   = 1'b1;
      if_pc_d      = skid_pc_q;
      if_instr_d   = skid_instr_q;
      skid_valid_d = 1'b0;
    end else if (if_valid_q && !i_id_stall) begin
      // Decode consumed the payload and nothing replaces it.
      if_valid_d = 1'b0;
      if_pc_d    = RESET_PC;
      if_instr_d = 32'h0;
    end

    req_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      drain_addr_q <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= RESET_PC;
      if_instr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      drain_addr_q <= drain_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

endmodule

`default_nettype wire
